imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the 64-word instruction memory; the other end of the fetch read path.
- Receives a little-endian byte stream over a valid/ready handshake: a 16-bit word count followed by the instruction words.
- Assembles each group of 4 bytes into a 32-bit word and issues one write per word to the memory's write port, at consecutive word-aligned byte addresses starting at 0.
- Holds the core in stall via busy until the image is loaded.

Parameters:
- DEPTH, 64: number of 32-bit words in instruction memory; maximum loadable count.
- BASE, 32'h0000_0000: byte address of the first word written.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  write enable to instruction memory, one cycle per word.
- waddr  output  32  byte address of the write; word-aligned, waddr[1:0]=0.
- wdata  output  32  assembled instruction word.
- busy  output  1  high from start acceptance until the cycle before done; core stall.
- done  output  1  one-cycle pulse when a load completes successfully.
- error  output  1  sticky; set on count > DEPTH, cleared on the next accepted start.

Behaviour:
- Reset values: state IDLE. in_ready, we, busy, done and error all 0. waddr=BASE, wdata=0. Byte index, word counter and length are 0.
- Handshake: a byte is accepted when in_valid && in_ready. in_ready is high only in LEN_LO, LEN_HI and DATA, combinationally from state. in_data must be held stable while in_valid && !in_ready.
- IDLE:
  - start moves to LEN_LO, sets busy and clears error.
  - in_valid is ignored; a byte presented in the same cycle as start is not accepted.
- LEN_LO: on accept, len[7:0]=in_data; go to LEN_HI.
- LEN_HI: on accept, len[15:8]=in_data, then:
  - len==0: go to DONE.
  - len>DEPTH: go to ERR.
  - otherwise: go to DATA with word counter=0 and byte index=0.
- DATA, little-endian assembly:
  - Byte index k (0..3) fills wdata[8k+7:8k].
  - On acceptance of byte 3, the next cycle has we=1, waddr=BASE+4*word, and wdata holding the full word. Latency from 4th byte accept to we is 1 cycle.
  - The byte index wraps to 0 and the word counter increments.
  - Bytes for the next word may be accepted in the same cycle we is high (full throughput: one word per 4 cycles).
- Final word: when the accepted byte is byte 3 of word len-1, the next cycle has we=1 and state=DONE. in_ready is 0 from that cycle on.
- DONE: busy=0, done=1 for exactly one cycle; next state IDLE.
- ERR: busy=0, error=1 (sticky), no writes issued; next state IDLE. Remaining stream bytes are not consumed by the loader.
- we is never asserted outside DATA completion, and at most len times per load. waddr never exceeds BASE+4*(DEPTH-1).
- start while busy is ignored.
- Reset mid-operation returns everything to reset values immediately. A partially assembled word is discarded with no write; words already written stay in memory.
- in_valid deasserted mid-word: assembly pauses and the byte index is held; no timeout.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 02 00 | 13 00 00 00 | 93 00 10 00, in_valid held high.
  - Response: we at 0x0 with wdata=0x00000013, then we at 0x4 with wdata=0x00100093, 4 cycles apart; done one cycle after the second we; busy high throughout until done.
- Zero count:
  - Stimulus: start, 00 00.
  - Response: no we; done pulse 1 cycle after the second byte accept; error=0.
- Overflow:
  - Stimulus: start, 41 00 (count 65 > 64).
  - Response: error=1, no we, busy low, in_ready=0, state IDLE. A following start with count 01 00 clears error and loads normally.
- Gapped stream:
  - Stimulus: count 1, word bytes EF BE AD DE with in_valid low 3 cycles between each byte.
  - Response: single we, waddr=0x0, wdata=0xDEADBEEF, 1 cycle after the last accept.
- Reset mid-word:
  - Stimulus: count 2, first word complete, 2 bytes of the second word, then reset pulse.
  - Response: exactly one we observed; all outputs at reset values. A new load of count 1 writes address 0x0 correctly.
- Full depth and start-while-busy:
  - Stimulus: count 64 (40 00), 256 bytes streamed continuously; start pulsed mid-load.
  - Response: 64 writes at 0x0..0xFC in order; the extra start has no effect; done once.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: takes a little-endian byte stream
// (16-bit word count, then words) and writes each assembled word at consecutive addresses.
module imem_loader #(
  parameter int          DEPTH = 64,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int          WW      = $clog2(DEPTH + 1);
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_len;
  logic [WW-1:0]   r_word;
  logic [1:0]      r_idx;
  logic            r_we;
  logic            r_error;
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;

  logic            w_accept;
  logic            w_start_acc;
  logic            w_word_end;
  logic            w_last;
  logic [15:0]     w_len_full;

  // Acceptance is derived from state directly so it does not depend on in_ready.
  assign w_accept   = in_valid &&
                      ((r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA));
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_word_end = w_accept && (r_state == S_DATA) && (r_idx == 2'd3);
  assign w_last     = w_word_end && ({{(16-WW){1'b0}}, r_word} == (r_len - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) begin
          if (w_len_full == 16'd0)       w_next = S_DONE;
          else if (w_len_full > DEPTH_L) w_next = S_ERR;
          else                           w_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      // The final write lands in the first DONE cycle; done follows it one cycle later.
      S_DONE: begin
        busy = r_we;
        done = !r_we;
        if (!r_we) w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_error <= 1'b0;
      r_waddr <= BASE;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_acc) r_error <= 1'b0;
      if (w_accept && (r_state == S_LEN_LO)) r_len[7:0] <= in_data;
      if (w_accept && (r_state == S_LEN_HI)) begin
        r_len[15:8] <= in_data;
        r_word      <= '0;
        r_idx       <= '0;
        if (w_len_full > DEPTH_L) r_error <= 1'b1;
      end
      if (w_accept && (r_state == S_DATA)) begin
        r_wdata[{r_idx, 3'b000} +: 8] <= in_data;
        r_idx                         <= r_idx + 2'd1;
        if (w_word_end) begin
          r_we    <= 1'b1;
          r_waddr <= BASE + {{(30-WW){1'b0}}, r_word, 2'b00};
          r_word  <= r_word + {{(WW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign error = r_error;

endmodule
